// File: rtl/iiitb_cg_pkg.sv
// Shared types and default widths for the clock-gating controller.
package iiitb_cg_pkg;

  typedef enum logic [1:0] {
    CG_OFF  = 2'd0,
    CG_WAKE = 2'd1,
    CG_ON   = 2'd2
  } cg_state_t;

  localparam int CNT_W_DEF  = 4;
  localparam int STAT_W_DEF = 16;

endpackage

// File: rtl/iiitb_cg_ctrl_if.sv
// Bundle between activity-detect logic (master) and the gating controller (slave).
interface iiitb_cg_ctrl_if #(
  parameter int N_DOM  = 2,
  parameter int STAT_W = 16
);
  logic [N_DOM-1:0]  req;
  logic              force_on;
  logic [N_DOM-1:0]  gate_en;
  logic [N_DOM-1:0]  ready;
  logic              all_off;
  logic [STAT_W-1:0] off_cnt;

  modport master (
    output req, force_on,
    input  gate_en, ready, all_off, off_cnt
  );

  modport slave (
    input  req, force_on,
    output gate_en, ready, all_off, off_cnt
  );
endinterface

// File: rtl/iiitb_cg_chan.sv
// One gated domain: OFF/WAKE/ON sequencer with a shared wake/idle down-counter.
module iiitb_cg_chan
  import iiitb_cg_pkg::*;
#(
  parameter int IDLE_CYCLES = 4,
  parameter int WAKE_CYCLES = 1,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      eff_req,
  output logic      gate_en,
  output logic      ready,
  output cg_state_t state,
  output cg_state_t state_nxt
);

  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYCLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      CG_OFF: begin
        if (eff_req) begin
          if (WAKE_CYCLES > 0) begin
            state_nxt = CG_WAKE;
            cnt_nxt   = WAKE_LD;
          end else begin
            state_nxt = CG_ON;
            cnt_nxt   = IDLE_LD;
          end
        end
      end
      CG_WAKE: begin
        // The wake always runs to completion; a dropped request is handled in ON.
        if (cnt <= ONE) begin
          state_nxt = CG_ON;
          cnt_nxt   = IDLE_LD;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      CG_ON: begin
        if (eff_req) begin
          cnt_nxt = IDLE_LD;
        end else if (cnt <= ONE) begin
          state_nxt = CG_OFF;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      default: begin
        state_nxt = CG_OFF;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Enables are flopped from the next state so they only move on rising edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CG_OFF;
      cnt     <= '0;
      gate_en <= 1'b0;
      ready   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      gate_en <= (state_nxt != CG_OFF);
      ready   <= (state_nxt == CG_ON);
    end
  end

endmodule

// File: rtl/iiitb_cg_ctrl.sv
// Clock-gating controller: N_DOM independent domain sequencers plus all-off statistics.
module iiitb_cg_ctrl
  import iiitb_cg_pkg::*;
#(
  parameter int N_DOM       = 2,
  parameter int IDLE_CYCLES = 4,
  parameter int WAKE_CYCLES = 1,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int STAT_W      = STAT_W_DEF
) (
  input logic           clk,
  input logic           rst,
  iiitb_cg_ctrl_if.slave bus
);

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [N_DOM-1:0]  gate_en_w;
  logic [N_DOM-1:0]  ready_w;
  cg_state_t         st_q   [N_DOM];
  cg_state_t         st_nxt [N_DOM];
  logic              off_nxt_all;
  logic              off_now_all;
  logic              all_off_q;
  logic [STAT_W-1:0] off_cnt_q;

  for (genvar i = 0; i < N_DOM; i++) begin : g_dom
    iiitb_cg_chan #(
      .IDLE_CYCLES (IDLE_CYCLES),
      .WAKE_CYCLES (WAKE_CYCLES),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .eff_req   (bus.req[i] | bus.force_on),
      .gate_en   (gate_en_w[i]),
      .ready     (ready_w[i]),
      .state     (st_q[i]),
      .state_nxt (st_nxt[i])
    );
  end

  always_comb begin
    off_nxt_all = 1'b1;
    off_now_all = 1'b1;
    for (int i = 0; i < N_DOM; i++) begin
      if (st_nxt[i] != CG_OFF) off_nxt_all = 1'b0;
      if (st_q[i]   != CG_OFF) off_now_all = 1'b0;
    end
  end

  // all_off tracks the registered gate_en; the counter also requires the domain states to agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      all_off_q <= 1'b1;
      off_cnt_q <= '0;
    end else begin
      all_off_q <= off_nxt_all;
      if (all_off_q && off_now_all) off_cnt_q <= sat_inc(off_cnt_q);
    end
  end

  assign bus.gate_en = gate_en_w;
  assign bus.ready   = ready_w;
  assign bus.all_off = all_off_q;
  assign bus.off_cnt = off_cnt_q;

endmodule

// File: tb/tb_iiitb_cg_ctrl.sv
// Directed bench for iiitb_cg_ctrl: expectations queued at drive time, checked after each edge.
module tb_iiitb_cg_ctrl;

  logic clk;
  logic rst;

  iiitb_cg_ctrl_if #(.N_DOM(2), .STAT_W(16)) bus ();
  iiitb_cg_ctrl_if #(.N_DOM(2), .STAT_W(4))  bus_s ();

  iiitb_cg_ctrl #(.N_DOM(2), .IDLE_CYCLES(4), .WAKE_CYCLES(1), .CNT_W(4), .STAT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  iiitb_cg_ctrl #(.N_DOM(2), .IDLE_CYCLES(4), .WAKE_CYCLES(1), .CNT_W(4), .STAT_W(4)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  typedef struct {
    string       tag;
    logic [1:0]  g;
    logic [1:0]  r;
    logic        a;
    logic [15:0] oc;
    logic [3:0]  sc;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        cur_a = 1'b1;
  logic [15:0] exp_off = '0;
  logic [3:0]  exp_sat = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [3:0] sat4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  task automatic cyc(input string tag, input logic [1:0] r, input logic f, input logic rs,
                     input logic [1:0] eg, input logic [1:0] er, input logic ea);
    exp_t e;
    bus.req        = r;
    bus.force_on   = f;
    bus_s.req      = 2'b00;
    bus_s.force_on = 1'b0;
    rst            = rs;
    exp_off = rs ? 16'd0 : (cur_a ? sat16(exp_off) : exp_off);
    exp_sat = rs ? 4'd0 : sat4(exp_sat);
    cur_a   = ea;
    e.tag = tag; e.g = eg; e.r = er; e.a = ea; e.oc = exp_off; e.sc = exp_sat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      n_vec++;
      assert (bus.gate_en === e.g) else begin
        n_err++; $error("FAIL %s gate_en observed=%b expected=%b", e.tag, bus.gate_en, e.g);
      end
      n_vec++;
      assert (bus.ready === e.r) else begin
        n_err++; $error("FAIL %s ready observed=%b expected=%b", e.tag, bus.ready, e.r);
      end
      n_vec++;
      assert (bus.all_off === e.a) else begin
        n_err++; $error("FAIL %s all_off observed=%b expected=%b", e.tag, bus.all_off, e.a);
      end
      n_vec++;
      assert (bus.off_cnt === e.oc) else begin
        n_err++; $error("FAIL %s off_cnt observed=%0d expected=%0d", e.tag, bus.off_cnt, e.oc);
      end
      n_vec++;
      assert (bus_s.off_cnt === e.sc) else begin
        n_err++; $error("FAIL %s sat_off_cnt observed=%0d expected=%0d", e.tag, bus_s.off_cnt, e.sc);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req = 2'b11; bus.force_on = 1'b0;
    bus_s.req = 2'b00; bus_s.force_on = 1'b0;

    // Reset with requests present, then counting while idle
    repeat (2) cyc("rst",      2'b11, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1);
    repeat (3) cyc("rst_idle", 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);

    // Wake latency on domain 0; domain 1 stays off
    cyc("wake_gate", 2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
    repeat (3) cyc("wake_on", 2'b01, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0);

    // Idle timeout
    repeat (3) cyc("idle_hold", 2'b00, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0);
    cyc("idle_off", 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);

    // Pulse in the last idle cycle reloads the counter
    cyc("p_wake", 2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
    cyc("p_on",   2'b01, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0);
    repeat (3) cyc("p_hold", 2'b00, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0);
    cyc("p_pulse", 2'b01, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0);
    repeat (3) cyc("p_hold2", 2'b00, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0);
    cyc("p_off", 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);

    // force_on for 11 edges with req low
    cyc("f_gate", 2'b00, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0);
    repeat (10) cyc("f_on", 2'b00, 1'b1, 1'b0, 2'b11, 2'b11, 1'b0);
    repeat (3) cyc("f_hold", 2'b00, 1'b0, 1'b0, 2'b11, 2'b11, 1'b0);
    cyc("f_off", 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);

    // Request dropped during WAKE does not abort it
    cyc("wd_pulse", 2'b10, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0);
    cyc("wd_on",    2'b00, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0);
    repeat (3) cyc("wd_hold", 2'b00, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0);
    cyc("wd_off", 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);

    // Reset with domain 0 in WAKE and domain 1 in ON
    cyc("mr_w1",  2'b10, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0);
    cyc("mr_on1", 2'b10, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0);
    cyc("mr_w0",  2'b11, 1'b0, 1'b0, 2'b11, 2'b10, 1'b0);
    cyc("mr_rst", 2'b11, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1);
    cyc("mr_rewake", 2'b11, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0);
    cyc("mr_on",     2'b11, 1'b0, 1'b0, 2'b11, 2'b11, 1'b0);
    repeat (3) cyc("mr_hold", 2'b00, 1'b0, 1'b0, 2'b11, 2'b11, 1'b0);
    cyc("mr_off", 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);

    // Long all-off stretch: 4-bit counter saturates at 15
    repeat (20) cyc("sat", 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
